// File: rtl/icache_fill_pkg.sv
// icache_fill shared definitions.
// Widths, strobe levels and refill state encodings.
package icache_fill_pkg;

  localparam int   AddrLen     = 32;
  localparam int   RegLen      = 32;
  localparam logic ResetEnable = 1'b1;
  localparam logic Valid       = 1'b1;
  localparam int   MemByteW    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/icache_fill.sv
// icache_fill: refills one cache word over the byte bus.
// Four byte reads are packed little-endian, then replace fires.
module icache_fill
  import icache_fill_pkg::*;
#(
  parameter int ADDR_W     = AddrLen,
  parameter int WORD_BYTES = 4,
  parameter int MEM_W      = MemByteW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              flush,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_rd,
  input  logic [MEM_W-1:0]  mem_din,
  output logic              replace,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [RegLen-1:0] fill_data,
  output logic              fill_valid,
  output logic              busy
);

  localparam int CW = $clog2(WORD_BYTES) + 1;
  localparam int BW = $clog2(WORD_BYTES);
  localparam logic [CW-1:0] NB   = CW'(WORD_BYTES);
  localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     cap_cnt;
  logic              rd_q;
  logic [MEM_W-1:0]  bytes_q [WORD_BYTES];
  logic              unused_lsb;

  assign unused_lsb = ^miss_addr[1:0];

  // State register; reset abandons any fill in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == ResetEnable) state <= IDLE;
    else                    state <= nxt;
  end

  // Next state: flush first, then grant loss, then last byte.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (miss_req && !flush) nxt = REQ;
      REQ: begin
        if (flush)        nxt = IDLE;
        else if (bus_gnt) nxt = FETCH;
      end
      FETCH: begin
        if (flush)                        nxt = IDLE;
        else if (!bus_gnt)                nxt = REQ;
        else if (rd_q && cap_cnt == LAST) nxt = DONE;
      end
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs: bus strobes in REQ/FETCH, word strobe in DONE.
  always_comb begin
    bus_req    = 1'b0;
    mem_rd     = 1'b0;
    mem_a      = '0;
    replace    = 1'b0;
    fill_valid = 1'b0;
    fill_addr  = '0;
    fill_data  = '0;
    busy       = (state != IDLE);
    unique case (state)
      REQ: bus_req = Valid;
      FETCH: begin
        bus_req = Valid;
        if (bus_gnt && !flush && issue_cnt < NB) begin
          mem_rd = Valid;
          mem_a  = base + ADDR_W'(issue_cnt);
        end
      end
      DONE: begin
        if (!flush) begin
          replace    = Valid;
          fill_valid = Valid;
          fill_addr  = base;
          for (int i = 0; i < WORD_BYTES; i++)
            fill_data[i*MEM_W +: MEM_W] = bytes_q[i];
        end
      end
      default: ;
    endcase
  end

  // Datapath: base latch, issue/capture counters, byte buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == ResetEnable) begin
      base      <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      rd_q      <= 1'b0;
      for (int i = 0; i < WORD_BYTES; i++)
        bytes_q[i] <= '0;
    end else begin
      rd_q <= mem_rd;
      unique case (state)
        IDLE: begin
          if (miss_req && !flush)
            base <= {miss_addr[ADDR_W-1:2], 2'b00};
        end
        REQ: begin
          issue_cnt <= '0;
          cap_cnt   <= '0;
        end
        FETCH: begin
          if (mem_rd) issue_cnt <= issue_cnt + ONE;
          if (rd_q) begin
            bytes_q[cap_cnt[BW-1:0]] <= mem_din;
            cap_cnt <= cap_cnt + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill.sv
// tb_icache_fill: vectors, corner sequences, random vs model.
// Memory is a pure function of address; fills checked against it.
module tb_icache_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        flush;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] mem_a;
  logic        mem_rd;
  logic [7:0]  mem_din;
  logic        replace;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        fill_valid;
  logic        busy;

  int nchk = 0;
  int nerr = 0;

  icache_fill dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .flush(flush),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .mem_a(mem_a), .mem_rd(mem_rd), .mem_din(mem_din),
    .replace(replace), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_valid(fill_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [31:0] a);
    case (a)
      32'h1000: memf = 8'h13;
      32'h1001: memf = 8'h05;
      32'h1002: memf = 8'h10;
      32'h1003: memf = 8'h00;
      default:  memf = a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8]
                       ^ a[31:24] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [31:0] expw(input logic [31:0] a);
    expw = {memf(a + 3), memf(a + 2), memf(a + 1), memf(a)};
  endfunction

  // byte memory: answers one cycle after mem_rd, junk otherwise
  always @(posedge clk)
    mem_din <= mem_rd ? memf(mem_a) : 8'($urandom);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // results of run_seq
  int          r_lat;
  int          r_nrep;
  int          r_first;
  logic [31:0] r_fa;
  logic [31:0] r_fd;
  logic [63:0] r_bh;
  logic [31:0] rdq[$];

  // one miss; lowm bit c drops bus_gnt in cycle c; flush at fl_at
  task automatic run_seq(input logic [31:0] addr,
                         input logic [63:0] lowm,
                         input int fl_at);
    rdq.delete();
    r_lat = -1; r_nrep = 0; r_first = -1;
    r_fa = '0; r_fd = '0; r_bh = '0;
    miss_addr = addr;
    miss_req  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus_gnt = !lowm[c];
      flush   = (c == fl_at);
      if (c == fl_at) miss_req = 1'b0;
      @(negedge clk);
      r_bh[c] = bus_req;
      if (mem_rd) begin
        rdq.push_back(mem_a);
        if (r_first < 0) r_first = c;
      end
      if (replace) begin
        r_nrep++;
        r_lat = c;
        r_fa  = fill_addr;
        r_fd  = fill_data;
      end
      tick();
      if (r_lat >= 0) miss_req = 1'b0;
      if (r_lat >= 0 && c >= r_lat + 1) break;
    end
    flush   = 1'b0;
    bus_gnt = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          gd;
    logic [31:0] ea;
    logic [31:0] ed;
    int          elat;
  } vec_t;

  vec_t vt[4];

  initial begin
    int          n;
    logic        rd_ok;
    logic [63:0] lowm;
    logic [63:0] bmask;
    int          bc[2];
    logic [31:0] ba[2];
    logic [31:0] bd[2];
    logic        pend;
    logic [31:0] paddr;
    int          pwait;
    int          fills;
    int          viol;

    vt[0] = '{32'h1002,     0, 32'h1000,     32'h00100513, 7};
    vt[1] = '{32'h1000,     3, 32'h1000,     32'h00100513, 10};
    vt[2] = '{32'h2001,     0, 32'h2000,     expw(32'h2000), 7};
    vt[3] = '{32'hFFFFFFFF, 1, 32'hFFFFFFFC, expw(32'hFFFFFFFC), 8};

    rst = 1'b1; miss_req = 1'b0; miss_addr = '0;
    flush = 1'b0; bus_gnt = 1'b1;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_replace", replace, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_fill_addr", fill_addr, 0);
    chk("rst_fill_data", fill_data, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      lowm  = ((64'd1 << (vt[v].gd + 1)) - 64'd1) ^ 64'd1;
      run_seq(vt[v].addr, lowm, -1);
      chk("vec_latency", r_lat, vt[v].elat);
      chk("vec_nrep", r_nrep, 1);
      chk("vec_fill_addr", r_fa, vt[v].ea);
      chk("vec_fill_data", r_fd, vt[v].ed);
      chk("vec_first_rd", r_first, 2 + vt[v].gd);
      rd_ok = (rdq.size() == 4);
      for (int i = 0; i < rdq.size(); i++)
        if (rdq[i] !== vt[v].ea + 32'(i)) rd_ok = 1'b0;
      chk("vec_reads", rd_ok, 1);
      bmask = ((64'd1 << vt[v].elat) - 64'd1) ^ 64'd1;
      chk("vec_bus_req", r_bh, bmask);
      tick();
    end

    // flush in cycle 4 aborts; a later miss still works
    run_seq(32'h1000, 64'd0, 4);
    chk("flush_nrep", r_nrep, 0);
    chk("flush_bus_req", r_bh, 64'h1E);
    run_seq(32'h2000, 64'd0, -1);
    chk("after_flush_lat", r_lat, 7);
    chk("after_flush_addr", r_fa, 32'h2000);
    chk("after_flush_data", r_fd, expw(32'h2000));
    tick();

    // grant lost in cycles 4-5, reads restart at byte 0
    run_seq(32'h1000, 64'h30, -1);
    chk("gntlost_nrep", r_nrep, 1);
    chk("gntlost_lat", r_lat, 12);
    chk("gntlost_data", r_fd, 32'h00100513);
    chk("gntlost_nreads", rdq.size(), 6);
    chk("gntlost_restart", rdq.size() > 2 ? rdq[2] : 32'hDEAD, 32'h1000);
    chk("gntlost_last", rdq.size() > 5 ? rdq[5] : 32'hDEAD, 32'h1003);
    tick();

    // asynchronous reset between edges in mid-FETCH
    miss_addr = 32'h1000; miss_req = 1'b1; bus_gnt = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("arst_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_bus_req", bus_req, 0);
    chk("arst_mem_rd", mem_rd, 0);
    chk("arst_mem_a", mem_a, 0);
    chk("arst_replace", replace, 0);
    miss_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (replace || busy) n++;
    end
    chk("arst_no_replace", n, 0);
    tick();

    // back-to-back: second miss taken right after first DONE
    miss_addr = 32'h1000; miss_req = 1'b1; bus_gnt = 1'b1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (replace && n < 2) begin
        bc[n] = c; ba[n] = fill_addr; bd[n] = fill_data;
        n++;
      end
      tick();
      if (n == 1) miss_addr = 32'h1004;
      if (n == 2) begin
        miss_req = 1'b0;
        break;
      end
    end
    chk("b2b_count", n, 2);
    chk("b2b_c0", bc[0], 7);
    chk("b2b_c1", bc[1], 15);
    chk("b2b_a0", ba[0], 32'h1000);
    chk("b2b_a1", ba[1], 32'h1004);
    chk("b2b_d0", bd[0], 32'h00100513);
    chk("b2b_d1", bd[1], expw(32'h1004));
    tick();

    // random: IF holds miss until fill_valid or redirect
    pend = 1'b0; paddr = '0; pwait = 0; fills = 0; viol = 0;
    for (int c = 0; c < 3000; c++) begin
      bus_gnt = ($urandom_range(0, 9) != 0);
      flush   = ($urandom_range(0, 39) == 0);
      if (flush) pend = 1'b0;
      else if (!pend && $urandom_range(0, 3) == 0) begin
        pend  = 1'b1;
        pwait = 0;
        paddr = $urandom_range(0, 1) ? $urandom
                                     : 32'($urandom_range(0, 4095));
      end
      miss_req  = pend;
      miss_addr = paddr;
      @(negedge clk);
      if (mem_rd && !bus_req) viol++;
      if (replace !== fill_valid) viol++;
      if (!mem_rd && mem_a != 0) viol++;
      if (!busy && (bus_req || mem_rd || replace)) viol++;
      if (replace) begin
        chk("rnd_pending", pend, 1);
        chk("rnd_addr", fill_addr, {paddr[31:2], 2'b00});
        chk("rnd_data", fill_data, expw({paddr[31:2], 2'b00}));
        fills++;
        pend = 1'b0;
      end
      if (pend) begin
        pwait++;
        if (pwait > 300) begin
          nchk++;
          nerr++;
          $display("FAIL rnd_timeout: got %0d cycles expected <=300",
                   pwait);
          pend = 1'b0;
        end
      end
      tick();
    end
    flush = 1'b0;
    miss_req = 1'b0;
    chk("rnd_invariants", viol, 0);
    chk("rnd_enough_fills", fills > 20, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
